// File: rtl/mod_updown_reg.sv
// mod_updown_reg: loadable up/down counter modulo MAX_VAL+1 with registered terminal-count pulse and sticky wrap flag.
// Latency: one clk from the sampling edge to out/tc/wrap; there is no combinational path from any input to any output.
// Backpressure: none, a command is accepted every cycle. Define MOD_UPDOWN_REG_SAT_EN to saturate at the ends instead of wrapping.
module mod_updown_reg #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = (2**WIDTH) - 1,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             clr,
  input  logic             ld,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_V = RST_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] out_nxt;
  logic             tc_nxt;
  logic             wrap_nxt;
  logic             at_max;
  logic             at_min;

  // All compares stay WIDTH bits wide, so MAX_VAL = 2**WIDTH-1 cannot overflow.
  assign at_max = (out == MAX_V);
  assign at_min = (out == '0);

  always_comb begin
    out_nxt  = out;
    tc_nxt   = 1'b0;
    wrap_nxt = wrap;
    if (clr) begin
      out_nxt  = RST_V;
      wrap_nxt = 1'b0;
    end else if (ld) begin
      out_nxt  = (in > MAX_V) ? MAX_V : in;
      wrap_nxt = 1'b0;
    end else if (inc && !dec) begin
      if (at_max) begin
        tc_nxt   = 1'b1;
        wrap_nxt = 1'b1;
`ifdef MOD_UPDOWN_REG_SAT_EN
        out_nxt  = out;
`else
        out_nxt  = '0;
`endif
      end else begin
        out_nxt = out + WIDTH'(1);
      end
    end else if (dec && !inc) begin
      if (at_min) begin
        tc_nxt   = 1'b1;
        wrap_nxt = 1'b1;
`ifdef MOD_UPDOWN_REG_SAT_EN
        out_nxt  = out;
`else
        out_nxt  = MAX_V;
`endif
      end else begin
        out_nxt = out - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= RST_V;
      tc   <= 1'b0;
      wrap <= 1'b0;
    end else begin
      out  <= out_nxt;
      tc   <= tc_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_mod_updown_reg.sv
// Bench for mod_updown_reg: three instances (MAX 200, 255, 9/RST 2) on shared stimulus,
// directed tables and sequences plus a randomised run against a behavioural model.
module tb_mod_updown_reg;

  localparam int NI = 3;
  localparam int MAXV [NI] = '{200, 255, 9};
  localparam int RSTV [NI] = '{0, 0, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0, ld = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout  [NI];
  logic       dtc   [NI];
  logic       dwrap [NI];

  int checks   = 0;
  int failures = 0;

  int m_out  [NI];
  bit m_tc   [NI];
  bit m_wrap [NI];

  always #5 clk = ~clk;

  mod_updown_reg #(.WIDTH(8), .MAX_VAL(200), .RST_VAL(0)) u_d200 (
    .clk(clk), .rst(rst), .in(din), .clr(clr), .ld(ld), .inc(inc), .dec(dec),
    .out(dout[0]), .tc(dtc[0]), .wrap(dwrap[0]));
  mod_updown_reg #(.WIDTH(8), .MAX_VAL(255), .RST_VAL(0)) u_d255 (
    .clk(clk), .rst(rst), .in(din), .clr(clr), .ld(ld), .inc(inc), .dec(dec),
    .out(dout[1]), .tc(dtc[1]), .wrap(dwrap[1]));
  mod_updown_reg #(.WIDTH(8), .MAX_VAL(9), .RST_VAL(2)) u_d9 (
    .clk(clk), .rst(rst), .in(din), .clr(clr), .ld(ld), .inc(inc), .dec(dec),
    .out(dout[2]), .tc(dtc[2]), .wrap(dwrap[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_out[k]  = RSTV[k];
      m_tc[k]   = 1'b0;
      m_wrap[k] = 1'b0;
    end
  endtask

  // Integer-domain model: step past either end, then decide wrap or saturate.
  task automatic model_update();
    int v;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < NI; k++) begin
      m_tc[k] = 1'b0;
      if (clr) begin
        m_out[k] = RSTV[k];
        m_wrap[k] = 1'b0;
      end else if (ld) begin
        m_out[k] = (int'(din) > MAXV[k]) ? MAXV[k] : int'(din);
        m_wrap[k] = 1'b0;
      end else if (inc != dec) begin
        v = m_out[k] + (inc ? 1 : -1);
        if (v < 0 || v > MAXV[k]) begin
          m_tc[k] = 1'b1;
          m_wrap[k] = 1'b1;
`ifdef MOD_UPDOWN_REG_SAT_EN
          v = m_out[k];
`else
          v = (v < 0) ? MAXV[k] : 0;
`endif
        end
        m_out[k] = v;
      end
    end
  endtask

  task automatic step(input logic r, input logic c, input logic l, input logic i,
                      input logic d, input logic [7:0] v);
    @(negedge clk);
    rst = r; clr = c; ld = l; inc = i; dec = d; din = v;
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic reset_mid_cycle(input string nm);
    @(posedge clk);
    #3;
    rst = 1'b1; clr = 1'b0; ld = 1'b0; inc = 1'b0; dec = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk({nm, "_out"}, dout[k], RSTV[k]);
      chk({nm, "_tc"}, dtc[k], 0);
      chk({nm, "_wrap"}, dwrap[k], 0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       c, l, i, d;
    logic [7:0] v;
    int         e_out;
    logic       e_tc, e_wrap;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // Vectors for the MAX_VAL=9, RST_VAL=2 instance, applied back to back.
    tbl[0]  = '{0, 1, 0, 0, 8'd5,   5, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 8'd0,   6, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 8'd0,   5, 0, 0};
    tbl[3]  = '{0, 0, 1, 1, 8'd0,   5, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 8'd0,   0, 0, 0};
`ifdef MOD_UPDOWN_REG_SAT_EN
    tbl[5]  = '{0, 0, 0, 1, 8'd0,   0, 1, 1};
    tbl[6]  = '{0, 0, 1, 1, 8'd0,   0, 0, 1};
`else
    tbl[5]  = '{0, 0, 0, 1, 8'd0,   9, 1, 1};
    tbl[6]  = '{0, 0, 1, 1, 8'd0,   9, 0, 1};
`endif
    tbl[7]  = '{1, 1, 1, 0, 8'd7,   2, 0, 0};
    tbl[8]  = '{0, 1, 0, 0, 8'hFF,  9, 0, 0};
`ifdef MOD_UPDOWN_REG_SAT_EN
    tbl[9]  = '{0, 0, 1, 0, 8'd0,   9, 1, 1};
    tbl[10] = '{0, 0, 1, 0, 8'd0,   9, 1, 1};
`else
    tbl[9]  = '{0, 0, 1, 0, 8'd0,   0, 1, 1};
    tbl[10] = '{0, 0, 1, 0, 8'd0,   1, 0, 1};
`endif
    tbl[11] = '{0, 1, 0, 0, 8'd9,   9, 0, 0};
    tbl[12] = '{0, 0, 0, 1, 8'd0,   8, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 8'd0,   8, 0, 0};
    tbl[14] = '{0, 1, 0, 1, 8'd3,   3, 0, 0};

    // Power-on reset state.
    #12;
    for (int k = 0; k < NI; k++) begin
      chk("por_out", dout[k], RSTV[k]);
      chk("por_tc", dtc[k], 0);
      chk("por_wrap", dwrap[k], 0);
    end
    model_reset();

    // Load and clamp on MAX_VAL=200.
    step(0, 0, 1, 0, 0, 8'h50);
    chk("ld_50_out", dout[0], 8'h50);
    step(0, 0, 1, 0, 0, 8'hFF);
    chk("ld_clamp_out", dout[0], 8'hC8);
    chk("ld_clamp_wrap", dwrap[0], 0);
    chk("ld_clamp_tc", dtc[0], 0);

    // Up across the top on MAX_VAL=255.
    step(0, 0, 1, 0, 0, 8'hFE);
    chk("up_ld_out", dout[1], 8'hFE);
    step(0, 0, 0, 1, 0, 8'h00);
    chk("up1_out", dout[1], 8'hFF);
    chk("up1_tc", dtc[1], 0);
    chk("up1_wrap", dwrap[1], 0);
    step(0, 0, 0, 1, 0, 8'h00);
`ifdef MOD_UPDOWN_REG_SAT_EN
    chk("up2_out", dout[1], 8'hFF);
`else
    chk("up2_out", dout[1], 8'h00);
`endif
    chk("up2_tc", dtc[1], 1);
    chk("up2_wrap", dwrap[1], 1);
    step(0, 0, 0, 1, 0, 8'h00);
`ifdef MOD_UPDOWN_REG_SAT_EN
    chk("up3_out", dout[1], 8'hFF);
    chk("up3_tc", dtc[1], 1);
`else
    chk("up3_out", dout[1], 8'h01);
    chk("up3_tc", dtc[1], 0);
`endif
    chk("up3_wrap", dwrap[1], 1);

    // Asynchronous reset mid-cycle, once from a plain value and once with wrap set.
    step(0, 0, 1, 0, 0, 8'h37);
    chk("pre_rst_out", dout[1], 8'h37);
    reset_mid_cycle("arst_a");
    step(0, 0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 0, 1, 8'h00);
    chk("pre_rst_tc", dtc[1], 1);
    chk("pre_rst_wrap", dwrap[1], 1);
    reset_mid_cycle("arst_b");

    for (int n = 0; n < 15; n++) begin
      step(0, tbl[n].c, tbl[n].l, tbl[n].i, tbl[n].d, tbl[n].v);
      chk($sformatf("tbl%0d_out", n), dout[2], tbl[n].e_out);
      chk($sformatf("tbl%0d_tc", n), dtc[2], tbl[n].e_tc);
      chk($sformatf("tbl%0d_wrap", n), dwrap[2], tbl[n].e_wrap);
    end

    for (int n = 0; n < 3000; n++) begin
      logic [7:0] v;
      v = ($urandom_range(3) == 0) ? 8'(250 + $urandom_range(5)) : 8'($urandom_range(255));
      step($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(7) == 0,
           1'($urandom_range(1)), 1'($urandom_range(1)), v);
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("rand%0d_inst%0d", n, k), {dout[k], dtc[k], dwrap[k]},
            {8'(m_out[k]), m_tc[k], m_wrap[k]});
        chk($sformatf("rand%0d_range%0d", n, k), (int'(dout[k]) <= MAXV[k]), 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
